uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Packet controller between the UART receiver/transmitter and a 32-bit ALU datapath. It parses framed command packets from the RX byte stream and sequences operand accumulation. It returns results, or echoes the payload, through the TX ready/valid interface. It sits in the 50 MHz domain between `uart_mod` RX/TX and the board top level.

## Interface
- `LEN_W`, 16: width of the packet length field and byte counter.
- `OP_ECHO`, 8'hEC: opcode that echoes payload bytes.
- `OP_ADD`, 8'hAD: opcode that sums 32-bit operands modulo 2^32.
- `OP_XOR`, 8'hA5: opcode that XORs 32-bit operands together.

- `clk_i`  in  1  system clock (50 MHz)
- `rst_i`  in  1  asynchronous, active-high reset
- `rx_valid_i`  in  1  single-cycle strobe: `rx_data_i` holds a received byte
- `rx_data_i`  in  8  received byte
- `tx_ready_i`  in  1  transmitter can accept a byte this cycle
- `tx_valid_o`  out  1  `tx_data_o` is valid; held until accepted
- `tx_data_o`  out  8  byte to transmit
- `busy_o`  out  1  high in every state except `S_OP`
- `err_o`  out  1  single-cycle pulse on a protocol or overflow error

## Operation
- Packet format: opcode, reserved byte (ignored), length LSB, length MSB, then payload. Length is the total packet byte count including the 4 header bytes. Payload bytes = max(len − 4, 0).
- States: `S_OP` → `S_RSV` → `S_LENL` → `S_LENH` → `S_PAY` (only if payload > 0) → `S_RES` (ADD/XOR only) → `S_OP`.
- Every state advances only on `rx_valid_i`, except `S_RES`, which advances on TX handshakes.
- In `S_LENH`, `remain` is loaded with len − 4 (saturating at 0).
  - If `remain` = 0: ADD/XOR go to `S_RES`; ECHO and unknown opcodes go to `S_OP`.
- In `S_PAY`, each accepted byte decrements `remain`. The last byte (`remain` = 1) exits the state.
- ECHO:
  - Each payload byte is copied into the TX holding register and `tx_valid_o` is set.
  - If a new byte arrives while `tx_valid_o` is still high and not being accepted that cycle, the byte is dropped and `err_o` pulses.
  - Exiting to `S_OP` does not clear a pending TX byte.
- ADD/XOR:
  - Payload bytes shift into a 32-bit operand register little-endian.
  - On every 4th payload byte, the accumulator is updated: `acc ← acc + opnd` (ADD) or `acc ← acc ^ opnd` (XOR).
  - `acc` clears to 0 in `S_LENH`.
  - A trailing partial operand (payload length not a multiple of 4) is discarded.
  - Zero full operands give result 0.
- Unknown opcode: payload is consumed and discarded, no response is sent, and `err_o` pulses once, in the cycle the opcode is accepted.
- `S_RES`: sends `acc` as 4 bytes, LSB first, one per `tx_valid_o && tx_ready_i` handshake. Returns to `S_OP` after the 4th handshake.
  - RX bytes arriving in `S_RES` are dropped and `err_o` pulses for each one.
- Reset:
  - All outputs are 0 and the state is `S_OP`.
  - `acc`, `opnd`, `remain`, byte index and TX holding register are cleared.
  - Reset mid-packet abandons the packet with no partial TX byte emitted.

## Timing
- RX byte accepted in the same cycle `rx_valid_i` is high; the state register updates on the next edge.
- ECHO latency: `tx_valid_o` rises 1 cycle after the `rx_valid_i` cycle.
- ADD/XOR: `acc` updates 1 cycle after the 4th operand byte strobe.
  - After the last payload byte, `tx_valid_o` rises 2 cycles after that byte's strobe (accumulate, then `S_RES`).
- TX handshake:
  - `tx_data_o` and `tx_valid_o` are stable while `tx_valid_o && !tx_ready_i`.
  - In `S_RES`, the next byte is presented in the cycle after a handshake.
  - `tx_valid_o` never deasserts without a handshake, except on reset.
- Simultaneous TX handshake and ECHO RX byte in the same cycle: the new byte is loaded with no error.
- `remain` arithmetic is `LEN_W` bits unsigned; a length of 0–4 never underflows.
- `busy_o` is registered with the state: low exactly when the state is `S_OP`.

## Test plan
- ADD packet `AD 00 0C 00 | 01 00 00 00 | 02 00 00 00`, with `tx_ready_i` = 1 → TX bytes `03 00 00 00`; `err_o` never pulses.
- XOR packet `A5 00 0B 00 | FF 00 FF 00 | 0F 0F 0F` (partial trailing operand) → TX `FF 00 FF 00`.
- ECHO packet `EC 00 07 00 | 41 42 43` with `tx_ready_i` = 1 → TX `41 42 43`.
  - Repeat with `tx_ready_i` held low for 20 cycles: `41` held stable on `tx_data_o`, `42` dropped with one `err_o` pulse.
- Unknown opcode `77 00 06 00 | AA BB`, then ADD `AD 00 04 00` → one `err_o` pulse and no TX for the first packet; the ADD returns `00 00 00 00`.
- Assert `rst_i` after the 2nd payload byte of an ADD → all outputs 0, state `S_OP`. A following ADD `AD 00 08 00 | 05 00 00 00` returns `05 00 00 00`.
- Random `tx_ready_i` throttling during an ADD result → exactly 4 handshakes in LSB-first order, data stable while stalled.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Purpose: parse framed UART command packets; echo payload or return ADD/XOR of 32-bit operands.
// Latency: echo byte on TX 1 cycle after its RX strobe; ALU result 2 cycles after last payload byte.
// Backpressure: TX holds data/valid until tx_ready_i; RX cannot stall, so blocked echo/result-phase bytes drop with err_o.
module uart_alu_ctrl #(
    parameter int         LEN_W   = 16,
    parameter logic [7:0] OP_ECHO = 8'hEC,
    parameter logic [7:0] OP_ADD  = 8'hAD,
    parameter logic [7:0] OP_XOR  = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_RSV  = 3'd1,
        S_LENL = 3'd2,
        S_LENH = 3'd3,
        S_PAY  = 3'd4,
        S_RES  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       opcode;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] remain_ld;
    logic [31:0]      acc;
    logic [31:0]      acc_nxt;
    logic [31:0]      opnd;
    logic [31:0]      opnd_nxt;
    logic [1:0]       byte_idx;
    logic [1:0]       res_idx;
    logic [1:0]       res_idx_inc;
    logic             res_act;
    logic             is_echo;
    logic             is_alu;
    logic             rx_known;
    logic             tx_free;
    logic             res_hs;

    assign busy_o = (state != S_OP);

    // Decode, operand/accumulator arithmetic and next-state selection.
    always_comb begin
        state_nxt   = state;
        is_echo     = (opcode == OP_ECHO);
        is_alu      = (opcode == OP_ADD) || (opcode == OP_XOR);
        rx_known    = (rx_data_i == OP_ECHO) || (rx_data_i == OP_ADD) || (rx_data_i == OP_XOR);
        len_full    = LEN_W'({rx_data_i, len_lo});
        remain_ld   = (len_full > LEN_W'(4)) ? (len_full - LEN_W'(4)) : '0;
        opnd_nxt    = {rx_data_i, opnd[31:8]};
        acc_nxt     = (opcode == OP_ADD) ? (acc + opnd_nxt) : (acc ^ opnd_nxt);
        // Holding register can take a new byte if empty or being drained this cycle.
        tx_free     = !tx_valid_o || tx_ready_i;
        // Only handshakes of result bytes advance the result index; a leftover echo byte does not.
        res_hs      = res_act && tx_valid_o && tx_ready_i;
        res_idx_inc = res_idx + 2'd1;
        case (state)
            S_OP:   if (rx_valid_i) state_nxt = S_RSV;
            S_RSV:  if (rx_valid_i) state_nxt = S_LENL;
            S_LENL: if (rx_valid_i) state_nxt = S_LENH;
            S_LENH: begin
                if (rx_valid_i) begin
                    if (remain_ld != '0) state_nxt = S_PAY;
                    else if (is_alu)     state_nxt = S_RES;
                    else                 state_nxt = S_OP;
                end
            end
            S_PAY: begin
                if (rx_valid_i && (remain == LEN_W'(1)))
                    state_nxt = is_alu ? S_RES : S_OP;
            end
            S_RES:  if (res_hs && (res_idx == 2'd3)) state_nxt = S_OP;
            default: state_nxt = S_OP;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_OP;
        else       state <= state_nxt;
    end

    // Packet datapath: header capture, operand accumulation, TX holding register and error pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcode     <= '0;
            len_lo     <= '0;
            remain     <= '0;
            acc        <= '0;
            opnd       <= '0;
            byte_idx   <= '0;
            res_idx    <= '0;
            res_act    <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (tx_valid_o && tx_ready_i) tx_valid_o <= 1'b0;
            case (state)
                S_OP: begin
                    if (rx_valid_i) begin
                        opcode <= rx_data_i;
                        if (!rx_known) err_o <= 1'b1;
                    end
                end
                S_LENL: if (rx_valid_i) len_lo <= rx_data_i;
                S_LENH: begin
                    if (rx_valid_i) begin
                        remain   <= remain_ld;
                        acc      <= '0;
                        opnd     <= '0;
                        byte_idx <= '0;
                        res_idx  <= '0;
                        res_act  <= 1'b0;
                    end
                end
                S_PAY: begin
                    if (rx_valid_i) begin
                        remain <= remain - LEN_W'(1);
                        if (is_echo) begin
                            if (tx_free) begin
                                tx_data_o  <= rx_data_i;
                                tx_valid_o <= 1'b1;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else if (is_alu) begin
                            opnd     <= opnd_nxt;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) acc <= acc_nxt;
                        end
                    end
                end
                S_RES: begin
                    if (rx_valid_i) err_o <= 1'b1;
                    if (tx_free) begin
                        if (res_hs) begin
                            if (res_idx == 2'd3) begin
                                res_act <= 1'b0;
                            end else begin
                                res_idx    <= res_idx_inc;
                                tx_data_o  <= acc[{res_idx_inc, 3'b000} +: 8];
                                tx_valid_o <= 1'b1;
                            end
                        end else begin
                            tx_data_o  <= acc[{res_idx, 3'b000} +: 8];
                            tx_valid_o <= 1'b1;
                            res_act    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Purpose: randomized and directed scoreboard bench for uart_alu_ctrl.
// Latency: expected TX bytes are queued at packet issue and popped on each TX handshake.
// Backpressure: tx_ready is held high, held low or randomized per packet.
module tb_uart_alu_ctrl;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_XOR  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         err_seen = 0;
    int         ready_mode = 1;
    logic [7:0] exp_q[$];

    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    uart_alu_ctrl #(
        .LEN_W(16), .OP_ECHO(OP_ECHO), .OP_ADD(OP_ADD), .OP_XOR(OP_XOR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_ready_i(tx_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .busy_o(busy), .err_o(err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected TX bytes from the packet contents; returns expected err pulses.
    function automatic int model_push(input logic [7:0] op, input logic [7:0] pay[$]);
        logic [31:0] sum = 32'h0;
        logic [31:0] w;
        if (op == OP_ECHO) begin
            foreach (pay[i]) exp_q.push_back(pay[i]);
            return 0;
        end
        if (op == OP_ADD || op == OP_XOR) begin
            for (int k = 0; k + 4 <= pay.size(); k += 4) begin
                w = {pay[k+3], pay[k+2], pay[k+1], pay[k]};
                sum = (op == OP_ADD) ? sum + w : sum ^ w;
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(8'((sum >> (8 * i)) & 32'hFF));
            return 0;
        end
        return 1;
    endfunction

    // tx_ready driver.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops scoreboard on handshakes, checks stall stability, counts err pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
            prev_d = 8'h00;
        end else begin
            if (err) err_seen++;
            if (prev_v && !prev_r) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_d);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_tx: got %02h expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (t < 300 && (exp_q.size() != 0 || busy || tx_valid)) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_timeout", (t >= 300), 0);
        if (t >= 300) exp_q.delete();
        idle(2);
    endtask

    task automatic run_pkt(input logic [7:0] op, input logic [15:0] len,
                           input logic [7:0] pay[$], input int maxgap);
        int exp_err;
        err_seen = 0;
        exp_err  = model_push(op, pay);
        send_byte(op);
        check("busy_after_op", busy, 1);
        idle($urandom_range(0, maxgap));
        send_byte(8'h00);
        idle($urandom_range(0, maxgap));
        send_byte(len[7:0]);
        idle($urandom_range(0, maxgap));
        send_byte(len[15:8]);
        foreach (pay[i]) begin
            idle($urandom_range(0, maxgap));
            send_byte(pay[i]);
        end
        if (op == OP_ADD || op == OP_XOR) begin
            check("alu_lat_early", tx_valid, 0);
            idle(1);
            check("alu_lat", tx_valid, 1);
        end else if (op == OP_ECHO && pay.size() != 0) begin
            check("echo_lat", tx_valid, 1);
        end
        wait_done();
        check("err_count", err_seen, exp_err);
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [7:0] op;
        int         npay;
        int         sel;
        logic [15:0] len;

        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pay[$];
        logic [7:0] op;
        int         npay;
        int         sel;
        logic [15:0] len;

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        idle(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        idle(2);

        ready_mode = 1;
        pay = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 16'd12, pay, 0);
        pay = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F, 8'h0F, 8'h0F};
        run_pkt(OP_XOR, 16'd11, pay, 0);
        pay = '{8'h41, 8'h42, 8'h43};
        run_pkt(OP_ECHO, 16'd7, pay, 0);

        // Echo with TX stalled: 41 held, 42 dropped, 43 sent after release.
        ready_mode = 0;
        idle(3);
        err_seen = 0;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h43);
        send_byte(OP_ECHO);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h41);
        send_byte(8'h42);
        idle(3);
        check("echo_stall_valid", tx_valid, 1);
        check("echo_stall_data", tx_data, 8'h41);
        idle(17);
        ready_mode = 1;
        idle(3);
        check("echo_drop_err", err_seen, 1);
        send_byte(8'h43);
        wait_done();
        check("echo_drop_err_final", err_seen, 1);

        // Unknown opcode consumed silently, then header-only ADD.
        pay = '{8'hAA, 8'hBB};
        run_pkt(8'h77, 16'd6, pay, 0);
        pay = {};
        run_pkt(OP_ADD, 16'd4, pay, 0);

        // Reset mid-packet abandons the ADD.
        err_seen = 0;
        send_byte(OP_ADD);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        rst = 1'b1;
        idle(2);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err, 0);
        rst = 1'b0;
        idle(2);
        pay = '{8'h05, 8'h00, 8'h00, 8'h00};
        run_pkt(OP_ADD, 16'd8, pay, 0);

        // ADD result under random TX throttling.
        ready_mode = 2;
        pay = {};
        for (int i = 0; i < 12; i++) pay.push_back(8'($urandom_range(0, 255)));
        run_pkt(OP_ADD, 16'd16, pay, 1);
        ready_mode = 1;

        // Random packets.
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = OP_ECHO;
                1: op = OP_ADD;
                2: op = OP_XOR;
                default: begin
                    do op = 8'($urandom_range(0, 255));
                    while (op == OP_ECHO || op == OP_ADD || op == OP_XOR);
                end
            endcase
            npay = $urandom_range(0, 14);
            len = (npay != 0) ? 16'(npay + 4) : 16'($urandom_range(0, 4));
            pay = {};
            for (int i = 0; i < npay; i++) pay.push_back(8'($urandom_range(0, 255)));
            ready_mode = (op == OP_ADD || op == OP_XOR) ? 2 : 1;
            idle(1);
            run_pkt(op, len, pay, 2);
            ready_mode = 1;
        end

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
